// File: rtl/parser_rule_cfg_arb_if.sv
// Request/response and rule-config bus bundle for parser_rule_cfg_arb.
// The slave modport is the arbiter; the master modport is the requester/layer side.
interface parser_rule_cfg_arb_if #(
  parameter int REQ_NUM   = 2,
  parameter int LAYER_NUM = 4
);
  // Handshake: a request transfers on a rising clock edge where i_req_valid[n] and
  // o_req_ready[n] are both high; o_req_ready never has more than one bit set and
  // o_resp_valid is a single-cycle pulse that cannot be backpressured.
  logic [REQ_NUM-1:0]              i_req_valid;
  logic [REQ_NUM-1:0]              i_req_wr;
  logic [REQ_NUM-1:0][31:0]        i_req_addr;
  logic [REQ_NUM-1:0][31:0]        i_req_wdata;
  logic [REQ_NUM-1:0]              o_req_ready;
  logic [REQ_NUM-1:0]              o_resp_valid;
  logic [31:0]                     o_resp_rdata;
  logic                            o_resp_err;
  logic [LAYER_NUM-1:0]            o_rule_wren;
  logic [LAYER_NUM-1:0]            o_rule_rden;
  logic [31:0]                     o_rule_addr;
  logic [31:0]                     o_rule_wdata;
  logic [LAYER_NUM-1:0]            i_rule_rdata_valid;
  logic [LAYER_NUM-1:0][31:0]      i_rule_rdata;

  modport slave (
    input  i_req_valid, i_req_wr, i_req_addr, i_req_wdata,
    input  i_rule_rdata_valid, i_rule_rdata,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
    output o_rule_wren, o_rule_rden, o_rule_addr, o_rule_wdata
  );

  modport master (
    output i_req_valid, i_req_wr, i_req_addr, i_req_wdata,
    output i_rule_rdata_valid, i_rule_rdata,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
    input  o_rule_wren, o_rule_rden, o_rule_addr, o_rule_wdata
  );
endinterface

// File: rtl/parser_rule_cfg_arb.sv
// Round-robin arbiter sharing the parser rule-config bus between requesters, one transaction at a time.
// Optional read-wait timeout is enabled by defining RULE_CFG_TIMEOUT_EN.
module parser_rule_cfg_arb #(
  parameter int LAYER_NUM     = 4,
  parameter int LAYER_IDX_W   = 2,
  parameter int LAYER_SEL_LSB = 24,
  parameter int REQ_NUM       = 2,
  parameter int TIMEOUT_CYC   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  parser_rule_cfg_arb_if.slave bus,
  output logic [1:0]           o_dbg_state
);
  localparam int ID_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam logic [31:0] LAYER_MASK = 32'((2 ** LAYER_IDX_W - 1) << LAYER_SEL_LSB);

  if (LAYER_NUM > (2 ** LAYER_IDX_W) || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("parser_rule_cfg_arb: invalid LAYER_NUM/LAYER_IDX_W/TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                  state;
  logic [ID_W-1:0]         ptr;
  logic [ID_W-1:0]         id_q;
  logic                    wr_q;
  logic [LAYER_IDX_W-1:0]  layer_q;
  logic                    layer_ok_q;

  logic                    grant_vld;
  logic [ID_W-1:0]         grant_id;
  logic [ID_W:0]           cand;
  logic                    req_wr;
  logic [31:0]             req_addr;
  logic [31:0]             req_wdata;
  logic [LAYER_IDX_W-1:0]  req_layer;
  logic                    req_layer_ok;
  logic                    sel_vld;
  logic [31:0]             sel_data;

`ifdef RULE_CFG_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0]        tmo_cnt;
`endif

  assign o_dbg_state = state;

  // Scan upward from the round-robin pointer, wrapping at REQ_NUM.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(REQ_NUM)) cand = cand - (ID_W + 1)'(REQ_NUM);
      if (!grant_vld && bus.i_req_valid[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_wr       = bus.i_req_wr[grant_id];
    req_addr     = bus.i_req_addr[grant_id];
    req_wdata    = bus.i_req_wdata[grant_id];
    req_layer    = req_addr[LAYER_SEL_LSB +: LAYER_IDX_W];
    req_layer_ok = ({1'b0, req_layer} < (LAYER_IDX_W + 1)'(LAYER_NUM));
  end

  always_comb begin
    bus.o_req_ready = '0;
    if (state == IDLE && grant_vld) bus.o_req_ready = REQ_NUM'(1) << grant_id;
  end

  // Only the latched layer's valid/data are observed; other layers are ignored.
  always_comb begin
    sel_vld  = 1'b0;
    sel_data = '0;
    for (int l = 0; l < LAYER_NUM; l++) begin
      if (layer_q == LAYER_IDX_W'(l)) begin
        sel_vld  = bus.i_rule_rdata_valid[l];
        sel_data = bus.i_rule_rdata[l];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      ptr              <= '0;
      id_q             <= '0;
      wr_q             <= 1'b0;
      layer_q          <= '0;
      layer_ok_q       <= 1'b0;
      bus.o_rule_wren  <= '0;
      bus.o_rule_rden  <= '0;
      bus.o_rule_addr  <= '0;
      bus.o_rule_wdata <= '0;
      bus.o_resp_valid <= '0;
      bus.o_resp_rdata <= '0;
      bus.o_resp_err   <= 1'b0;
`ifdef RULE_CFG_TIMEOUT_EN
      tmo_cnt          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            id_q       <= grant_id;
            wr_q       <= req_wr;
            layer_q    <= req_layer;
            layer_ok_q <= req_layer_ok;
            ptr        <= (grant_id == ID_W'(REQ_NUM - 1)) ? '0 : grant_id + 1'b1;
            // Strobes and bus fields are registered here so they appear only during ISSUE.
            if (req_layer_ok) begin
              bus.o_rule_addr  <= req_addr & ~LAYER_MASK;
              bus.o_rule_wdata <= req_wdata;
              if (req_wr) bus.o_rule_wren <= LAYER_NUM'(1) << req_layer;
              else        bus.o_rule_rden <= LAYER_NUM'(1) << req_layer;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          bus.o_rule_wren  <= '0;
          bus.o_rule_rden  <= '0;
          bus.o_rule_addr  <= '0;
          bus.o_rule_wdata <= '0;
          if (!layer_ok_q || wr_q || sel_vld) begin
            bus.o_resp_valid <= REQ_NUM'(1) << id_q;
            bus.o_resp_err   <= !layer_ok_q;
            bus.o_resp_rdata <= (layer_ok_q && !wr_q) ? sel_data : 32'h0;
            state            <= RESP;
          end else begin
`ifdef RULE_CFG_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (sel_vld) begin
            bus.o_resp_valid <= REQ_NUM'(1) << id_q;
            bus.o_resp_err   <= 1'b0;
            bus.o_resp_rdata <= sel_data;
            state            <= RESP;
          end
`ifdef RULE_CFG_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            bus.o_resp_valid <= REQ_NUM'(1) << id_q;
            bus.o_resp_err   <= 1'b1;
            bus.o_resp_rdata <= 32'h0;
            state            <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          bus.o_resp_valid <= '0;
          bus.o_resp_rdata <= '0;
          bus.o_resp_err   <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_parser_rule_cfg_arb.sv
// Scoreboard bench for parser_rule_cfg_arb: a 4-layer instance for the main flows and a
// 3-layer instance for out-of-range layer errors.
module tb_parser_rule_cfg_arb;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state3;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int hs_count = 0;
  int hs3_cyc = 0;
  int hs3_count = 0;
  int idle_viol = 0;
  int strobe3_bad = 0;

  // grant: ready onehot; strobe: {wren,rden,addr,wdata}; resp: {valid,rdata,err,lat}; rd: {never,delay,data}
  logic [1:0]  grant_q[$];
  logic [71:0] strobe_q[$];
  logic [42:0] resp_q[$];
  logic [40:0] rd_q[$];
  logic [42:0] resp3_q[$];

  parser_rule_cfg_arb_if #(.REQ_NUM(2), .LAYER_NUM(4)) bus ();
  parser_rule_cfg_arb_if #(.REQ_NUM(2), .LAYER_NUM(3)) bus3 ();

  parser_rule_cfg_arb #(
    .LAYER_NUM(4), .LAYER_IDX_W(2), .LAYER_SEL_LSB(24), .REQ_NUM(2), .TIMEOUT_CYC(16)
  ) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus), .o_dbg_state(dbg_state)
  );

  parser_rule_cfg_arb #(
    .LAYER_NUM(3), .LAYER_IDX_W(2), .LAYER_SEL_LSB(24), .REQ_NUM(2), .TIMEOUT_CYC(16)
  ) u_dut3 (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus3), .o_dbg_state(dbg_state3)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc = cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard producers
  task automatic expect_txn(input logic [1:0] exp_grant, input logic [7:0] exp_en,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                            input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                            input logic exp_err, input logic [7:0] exp_lat);
    grant_q.push_back(exp_grant);
    if (exp_en != 8'h0) strobe_q.push_back({exp_en, exp_addr, exp_wdata});
    if (exp_resp != 2'b00) resp_q.push_back({exp_resp, exp_rdata, exp_err, exp_lat});
  endtask

  task automatic plan_read(input logic [7:0] delay, input logic [31:0] data, input logic never);
    rd_q.push_back({never, delay, data});
  endtask

  // driver tasks
  task automatic drive_req(input logic id, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
    bus.i_req_wr[id]    = wr;
    bus.i_req_addr[id]  = addr;
    bus.i_req_wdata[id] = wdata;
    bus.i_req_valid[id] = 1'b1;
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 200) begin
      @(negedge i_clk); #1;
      n++;
    end
    if (hs_count < target) check("handshake_timeout", 72'(hs_count), 72'(target));
  endtask

  task automatic wait_hs3(input int target);
    int n = 0;
    while (hs3_count < target && n < 200) begin
      @(negedge i_clk); #1;
      n++;
    end
    if (hs3_count < target) check("handshake3_timeout", 72'(hs3_count), 72'(target));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((resp_q.size() != 0 || strobe_q.size() != 0 || resp3_q.size() != 0) && n < 100) begin
      @(negedge i_clk); #1;
      n++;
    end
    if (n >= 100)
      check("drain_timeout", 72'(resp_q.size() + strobe_q.size() + resp3_q.size()), 72'(0));
    repeat (2) @(posedge i_clk);
  endtask

  task automatic run_one(input logic id, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int tgt = hs_count + 1;
    @(posedge i_clk); #1;
    drive_req(id, wr, addr, wdata);
    wait_hs(tgt);
    @(posedge i_clk); #1;
    bus.i_req_valid[id] = 1'b0;
    wait_drain();
  endtask

  task automatic check_all_zero(input string name);
    check(name, 72'({bus.o_req_ready, bus.o_resp_valid, bus.o_resp_rdata, bus.o_resp_err,
                     bus.o_rule_wren, bus.o_rule_rden, dbg_state}), 72'(0));
    check({name, "_rule_bus"}, 72'({bus.o_rule_addr, bus.o_rule_wdata}), 72'(0));
  endtask

  // monitor / scoreboard consumer for the 4-layer instance
  always @(negedge i_clk) begin
    logic [1:0]  eg;
    logic [71:0] es;
    logic [42:0] er;
    if (!i_rst) begin
      if (|bus.o_req_ready) begin
        hs_cyc = cyc;
        hs_count++;
        if (grant_q.size() == 0) check("unexpected_grant", 72'(bus.o_req_ready), 72'(0));
        else begin
          eg = grant_q.pop_front();
          check("grant", 72'(bus.o_req_ready), 72'(eg));
        end
      end
      if (|{bus.o_rule_wren, bus.o_rule_rden}) begin
        check("strobe_onehot", 72'($countones({bus.o_rule_wren, bus.o_rule_rden})), 72'(1));
        if (strobe_q.size() == 0)
          check("unexpected_strobe", 72'({bus.o_rule_wren, bus.o_rule_rden}), 72'(0));
        else begin
          es = strobe_q.pop_front();
          check("strobe_en", 72'({bus.o_rule_wren, bus.o_rule_rden}), 72'(es[71:64]));
          check("rule_addr", 72'(bus.o_rule_addr), 72'(es[63:32]));
          check("rule_wdata", 72'(bus.o_rule_wdata), 72'(es[31:0]));
          check("strobe_lat", 72'(cyc - hs_cyc), 72'(1));
        end
      end else if (bus.o_rule_addr != 32'h0 || bus.o_rule_wdata != 32'h0) begin
        idle_viol++;
      end
      if (|bus.o_resp_valid) begin
        if (resp_q.size() == 0) check("unexpected_resp", 72'(bus.o_resp_valid), 72'(0));
        else begin
          er = resp_q.pop_front();
          check("resp_valid", 72'(bus.o_resp_valid), 72'(er[42:41]));
          check("resp_rdata", 72'(bus.o_resp_rdata), 72'(er[40:9]));
          check("resp_err", 72'(bus.o_resp_err), 72'(er[8]));
          check("resp_lat", 72'(cyc - hs_cyc), 72'(er[7:0]));
        end
      end
    end
  end

  // monitor for the 3-layer instance
  always @(negedge i_clk) begin
    logic [42:0] er;
    if (!i_rst) begin
      if (|bus3.o_req_ready) begin
        hs3_cyc = cyc;
        hs3_count++;
      end
      if (|{bus3.o_rule_wren, bus3.o_rule_rden} || bus3.o_rule_addr != 32'h0 ||
          bus3.o_rule_wdata != 32'h0)
        strobe3_bad++;
      if (|bus3.o_resp_valid) begin
        if (resp3_q.size() == 0) check("unexpected_resp3", 72'(bus3.o_resp_valid), 72'(0));
        else begin
          er = resp3_q.pop_front();
          check("resp3_valid", 72'(bus3.o_resp_valid), 72'(er[42:41]));
          check("resp3_rdata", 72'(bus3.o_resp_rdata), 72'(er[40:9]));
          check("resp3_err", 72'(bus3.o_resp_err), 72'(er[8]));
          check("resp3_lat", 72'(cyc - hs3_cyc), 72'(er[7:0]));
        end
      end
    end
  end

  // layer responder: answers each read strobe after the planned delay
  initial begin : responder
    logic [40:0] e;
    logic [1:0]  lyr;
    logic [1:0]  other;
    forever begin
      @(negedge i_clk);
      if (!i_rst && |bus.o_rule_rden) begin
        lyr = 2'd0;
        for (int l = 0; l < 4; l++) if (bus.o_rule_rden[l]) lyr = 2'(l);
        other = lyr + 2'd1;
        if (rd_q.size() == 0) check("unexpected_read", 72'(bus.o_rule_rden), 72'(0));
        else begin
          e = rd_q.pop_front();
          if (!e[40]) begin
            for (int i = 1; i <= int'(e[39:32]); i++) begin
              @(negedge i_clk);
              bus.i_rule_rdata_valid = '0;
              if (i == 1) begin
                bus.i_rule_rdata_valid[other] = 1'b1;
                bus.i_rule_rdata[other]       = 32'hBAD0_BAD0;
              end
            end
            bus.i_rule_rdata_valid      = '0;
            bus.i_rule_rdata_valid[lyr] = 1'b1;
            bus.i_rule_rdata[lyr]       = e[31:0];
            @(negedge i_clk);
            bus.i_rule_rdata_valid = '0;
            bus.i_rule_rdata       = '0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int tgt;
    bus.i_req_valid  = '0; bus.i_req_wr  = '0; bus.i_req_addr  = '0; bus.i_req_wdata  = '0;
    bus3.i_req_valid = '0; bus3.i_req_wr = '0; bus3.i_req_addr = '0; bus3.i_req_wdata = '0;
    bus.i_rule_rdata_valid  = '0; bus.i_rule_rdata  = '0;
    bus3.i_rule_rdata_valid = '0; bus3.i_rule_rdata = '0;

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_all_zero("reset_outputs");
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // requester 0 writes layer 1
    expect_txn(2'b01, 8'b0010_0000, 32'h0000_0010, 32'hDEAD_BEEF, 2'b01, 32'h0, 1'b0, 8'd2);
    run_one(1'b0, 1'b1, 32'h0100_0010, 32'hDEAD_BEEF);

    // requester 1 reads layer 2, data returned with the strobe
    plan_read(8'd0, 32'h1234_5678, 1'b0);
    expect_txn(2'b10, 8'b0000_0100, 32'h0000_0004, 32'hAAAA_0001, 2'b10, 32'h1234_5678, 1'b0, 8'd2);
    run_one(1'b1, 1'b0, 32'h0200_0004, 32'hAAAA_0001);

    // requester 1 reads layer 3, data 5 cycles late, stray valid on layer 0 meanwhile
    plan_read(8'd5, 32'hCAFE_F00D, 1'b0);
    expect_txn(2'b10, 8'b0000_1000, 32'h0000_0100, 32'h0, 2'b10, 32'hCAFE_F00D, 1'b0, 8'd7);
    run_one(1'b1, 1'b0, 32'h0300_0100, 32'h0);

    // both requesters held valid: grants alternate 0,1,0,1
    for (int i = 0; i < 2; i++) begin
      expect_txn(2'b01, 8'b0001_0000, 32'h0000_0020, 32'h1111_0000, 2'b01, 32'h0, 1'b0, 8'd2);
      expect_txn(2'b10, 8'b0010_0000, 32'h0000_0030, 32'h2222_0000, 2'b10, 32'h0, 1'b0, 8'd2);
    end
    tgt = hs_count + 4;
    @(posedge i_clk); #1;
    drive_req(1'b0, 1'b1, 32'h0000_0020, 32'h1111_0000);
    drive_req(1'b1, 1'b1, 32'h0100_0030, 32'h2222_0000);
    wait_hs(tgt);
    @(posedge i_clk); #1;
    bus.i_req_valid = '0;
    wait_drain();

`ifdef RULE_CFG_TIMEOUT_EN
    // read that never returns data times out after 16 cycles in WAIT_RD
    plan_read(8'd0, 32'h0, 1'b1);
    expect_txn(2'b01, 8'b0000_0010, 32'h0000_0040, 32'h0, 2'b01, 32'h0, 1'b1, 8'd18);
    run_one(1'b0, 1'b0, 32'h0100_0040, 32'h0);
`endif

    // reset while waiting for read data: no response, pointer back to requester 0
    plan_read(8'd0, 32'h0, 1'b1);
    expect_txn(2'b01, 8'b0000_0001, 32'h0000_0008, 32'h0, 2'b00, 32'h0, 1'b0, 8'd0);
    tgt = hs_count + 1;
    @(posedge i_clk); #1;
    drive_req(1'b0, 1'b0, 32'h0000_0008, 32'h0);
    wait_hs(tgt);
    @(posedge i_clk); #1;
    bus.i_req_valid = '0;
    repeat (4) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check_all_zero("reset_in_wait_rd");
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (4) @(posedge i_clk);

    expect_txn(2'b01, 8'b0100_0000, 32'h0000_0050, 32'h3333_0000, 2'b01, 32'h0, 1'b0, 8'd2);
    expect_txn(2'b10, 8'b0001_0000, 32'h0000_0060, 32'h4444_0000, 2'b10, 32'h0, 1'b0, 8'd2);
    tgt = hs_count + 2;
    @(posedge i_clk); #1;
    drive_req(1'b0, 1'b1, 32'h0200_0050, 32'h3333_0000);
    drive_req(1'b1, 1'b1, 32'h0000_0060, 32'h4444_0000);
    wait_hs(tgt);
    @(posedge i_clk); #1;
    bus.i_req_valid = '0;
    wait_drain();

    // 3-layer instance: layer field 3 is out of range for reads and writes
    bus3.i_rule_rdata_valid = 3'b111;
    bus3.i_rule_rdata       = {3{32'h5555_5555}};
    resp3_q.push_back({2'b01, 32'h0, 1'b1, 8'd2});
    tgt = hs3_count + 1;
    @(posedge i_clk); #1;
    bus3.i_req_wr[0] = 1'b0; bus3.i_req_addr[0] = 32'h0300_0044; bus3.i_req_wdata[0] = 32'h0;
    bus3.i_req_valid[0] = 1'b1;
    wait_hs3(tgt);
    @(posedge i_clk); #1;
    bus3.i_req_valid = '0;
    wait_drain();

    resp3_q.push_back({2'b10, 32'h0, 1'b1, 8'd2});
    tgt = hs3_count + 1;
    @(posedge i_clk); #1;
    bus3.i_req_wr[1] = 1'b1; bus3.i_req_addr[1] = 32'h0300_0000; bus3.i_req_wdata[1] = 32'h7777;
    bus3.i_req_valid[1] = 1'b1;
    wait_hs3(tgt);
    @(posedge i_clk); #1;
    bus3.i_req_valid = '0;
    wait_drain();
    repeat (4) @(posedge i_clk);

    // final report
    check("grant_q_left", 72'(grant_q.size()), 72'(0));
    check("strobe_q_left", 72'(strobe_q.size()), 72'(0));
    check("resp_q_left", 72'(resp_q.size() + resp3_q.size()), 72'(0));
    check("rd_q_left", 72'(rd_q.size()), 72'(0));
    check("idle_bus_drive", 72'(idle_viol), 72'(0));
    check("dut3_strobe", 72'(strobe3_bad), 72'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
